div24x12: RTL and testbench
===========================

DIV24X12 -- requirements
Module: div24x12

Interface
REQ-001 SHALL use parameter DW_N, default 24, dividend and quotient width.
REQ-002 SHALL use parameter DW_D, default 12, divisor and remainder width.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port dividend, input, DW_N: numerator, unsigned.
REQ-006 SHALL have port divisor, input, DW_D: denominator, unsigned.
REQ-007 SHALL have port start, input, 1: request, sampled only in IDLE.
REQ-008 SHALL have port quotient, output, DW_N: registered result.
REQ-009 SHALL have port remainder, output, DW_D: registered result.
REQ-010 SHALL have port busy, output, 1: high while a division is in progress.
REQ-011 SHALL have port done, output, 1: single-cycle completion pulse.
REQ-012 SHALL have port div_by_zero, output, 1: valid with done; high when divisor was 0.

Function
REQ-013 SHALL be an unsigned 24/12 divider and the inverse of the 12x12 product path, with the same start/done handshake style.
REQ-014 SHALL implement FSM states IDLE, RUN and FIN:
- IDLE to RUN on start with nonzero divisor.
- IDLE to FIN on start with zero divisor.
- RUN to FIN after the iteration counter reaches 23.
- FIN to IDLE unconditionally.
REQ-015 SHALL latch dividend and divisor at the edge that samples start in IDLE; input changes after that edge SHALL have no effect.
REQ-016 SHALL, in RUN, use restoring radix-2 division at one quotient bit per cycle, MSB first, over 24 iterations:
- Partial remainder is DW_D+1 bits wide.
- Counter is 5 bits, counting 0..23.
REQ-017 SHALL, for nonzero divisor, register quotient and remainder at entry to FIN and pulse done for exactly one cycle, 25 cycles after the start-sampling edge.
REQ-018 SHALL, for zero divisor, set quotient=24'hFFFFFF, remainder=12'hFFF and div_by_zero=1, with done asserted 1 cycle after the start-sampling edge.
REQ-019 SHALL assert busy in RUN and FIN and deassert it in IDLE.
REQ-020 SHALL ignore start while busy; no queuing and no restart.
REQ-021 SHALL, when start is held high continuously, begin the next division on the first IDLE cycle, giving back-to-back operations every 26 cycles.
REQ-022 SHALL hold quotient, remainder and div_by_zero stable from done until the next FIN.
REQ-023 SHALL guarantee remainder < divisor and quotient*divisor+remainder == dividend for every nonzero divisor.

Reset
REQ-024 SHALL, while reset is high at a clock edge, force state=IDLE, counter=0, and quotient, remainder, busy, done and div_by_zero to 0.
REQ-025 SHALL let reset mid-RUN abort the operation with no done pulse; reset SHALL take priority over start in the same cycle.
REQ-026 SHALL sample start at the first edge after reset deasserts.

Structure
REQ-027 SHALL take DW_N, DW_D, the state enum type and the counter width from shared package arith_pkg, which the multiplier shall also use for its widths.
REQ-028 SHALL place one subtract-compare iteration in sub-module div_step:
- Inputs: partial remainder, next dividend bit, divisor.
- Outputs: new partial remainder, quotient bit.
- Purely combinational.
REQ-029 SHALL contain no combinational path from any input to any output.

Verification
REQ-030 SHALL verify that dividend=100, divisor=7, start for 1 cycle -> done at cycle 25 with quotient=14, remainder=2, div_by_zero=0.
REQ-031 SHALL verify that dividend=24'hFFFFFF, divisor=12'hFFF -> quotient=24'h001001, remainder=0.
REQ-032 SHALL verify that dividend=1234, divisor=0 -> done at cycle 1 with quotient=24'hFFFFFF, remainder=12'hFFF, div_by_zero=1.
REQ-033 SHALL verify that start pulses at cycles 5 and 10 of a 100/7 run with different operands -> exactly one done, carrying 100/7 results.
REQ-034 SHALL verify that reset asserted at cycle 12 of a run -> outputs 0, no done; a new start of 50/5 after release -> quotient=10, remainder=0.
REQ-035 SHALL verify round-trip with the multiplier: a=12'hABC, b=12'h123, product divided by b -> quotient=12'hABC, remainder=0; also 1000 random operand pairs satisfy REQ-023.

Source files
------------

// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared widths and state type for the multiply/divide datapaths
package arith_pkg;

   localparam int ARITH_DW_N   = 24;
   localparam int ARITH_DW_D   = 12;
   localparam int ARITH_CNT_W  = 5;
   localparam int ARITH_PROD_W = 2 * ARITH_DW_D;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } arith_state_e;

endpackage

// File: rtl/div24x12_if.sv
// rtl/div24x12_if.sv - operand/result/handshake bundle for the 24/12 divider
interface div24x12_if #(
   parameter int DW_N = 24,
   parameter int DW_D = 12
);
   logic [DW_N-1:0] dividend;
   logic [DW_D-1:0] divisor;
   logic            start;
   logic [DW_N-1:0] quotient;
   logic [DW_D-1:0] remainder;
   logic            busy;
   logic            done;
   logic            div_by_zero;

   modport master (
      output dividend, divisor, start,
      input  quotient, remainder, busy, done, div_by_zero
   );

   modport slave (
      input  dividend, divisor, start,
      output quotient, remainder, busy, done, div_by_zero
   );
endinterface

// File: rtl/div24x12_step.sv
// rtl/div24x12_step.sv - one restoring subtract-compare iteration
module div_step #(
   parameter int DW_D = 12
) (
   input  logic [DW_D:0]   rem_i,
   input  logic            bit_i,
   input  logic [DW_D-1:0] divisor_i,
   output logic [DW_D:0]   rem_o,
   output logic            qbit_o
);
   logic [DW_D+1:0] trial;

   always_comb begin
      trial  = {rem_i, bit_i};
      qbit_o = (trial >= {2'b00, divisor_i});
      rem_o  = qbit_o ? (trial[DW_D:0] - {1'b0, divisor_i}) : trial[DW_D:0];
   end
endmodule

// File: rtl/div24x12.sv
// rtl/div24x12.sv - unsigned 24/12 restoring divider, one quotient bit per cycle
module div24x12
   import arith_pkg::*;
#(
   parameter int DW_N = ARITH_DW_N,
   parameter int DW_D = ARITH_DW_D
) (
   input  logic      clk,
   input  logic      reset,
   div24x12_if.slave bus
);
   localparam logic [ARITH_CNT_W-1:0] LAST_ITER = ARITH_CNT_W'(DW_N - 1);

   arith_state_e           state_q, state_d;
   logic [ARITH_CNT_W-1:0] cnt_q, cnt_d;
   logic [DW_N-1:0]        dvd_q, dvd_d;
   logic [DW_D-1:0]        dsr_q, dsr_d;
   logic [DW_D:0]          rem_q, rem_d;
   logic [DW_N-1:0]        quotient_q, quotient_d;
   logic [DW_D-1:0]        remainder_q, remainder_d;
   logic                   dbz_q, dbz_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   logic [DW_D:0]          step_rem;
   logic                   step_qbit;

   div_step #(.DW_D(DW_D)) u_step (
      .rem_i     (rem_q),
      .bit_i     (dvd_q[DW_N-1]),
      .divisor_i (dsr_q),
      .rem_o     (step_rem),
      .qbit_o    (step_qbit)
   );

   // dvd_q shifts dividend bits out of the top while quotient bits enter at the bottom
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dvd_d       = dvd_q;
      dsr_d       = dsr_q;
      rem_d       = rem_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               dvd_d = bus.dividend;
               dsr_d = bus.divisor;
               rem_d = '0;
               cnt_d = '0;
               if (bus.divisor == '0) begin
                  state_d     = FIN;
                  quotient_d  = '1;
                  remainder_d = '1;
                  dbz_d       = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            rem_d = step_rem;
            dvd_d = {dvd_q[DW_N-2:0], step_qbit};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
               state_d     = FIN;
               cnt_d       = '0;
               quotient_d  = {dvd_q[DW_N-2:0], step_qbit};
               remainder_d = step_rem[DW_D-1:0];
               dbz_d       = 1'b0;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == FIN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         dvd_q       <= '0;
         dsr_q       <= '0;
         rem_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dvd_q       <= dvd_d;
         dsr_q       <= dsr_d;
         rem_q       <= rem_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.quotient    = quotient_q;
   assign bus.remainder   = remainder_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
endmodule

// File: tb/tb_div24x12.sv
// tb/tb_div24x12.sv - self-checking bench for div24x12 against an arithmetic model
module tb_div24x12;
   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   div24x12_if #(.DW_N(24), .DW_D(12)) bus ();

   div24x12 dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Drives one operation and returns the observed latency (edges after start sample, +1) and results.
   task automatic do_div(input logic [23:0] a, input logic [11:0] b, output int lat,
                         output logic [23:0] q, output logic [11:0] r, output logic z);
      @(negedge clk);
      bus.dividend = a;
      bus.divisor  = b;
      bus.start    = 1'b1;
      @(posedge clk); #1;
      bus.start    = 1'b0;
      bus.dividend = 24'($urandom);
      bus.divisor  = 12'($urandom);
      lat = 1;
      while (!bus.done && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      q = bus.quotient;
      r = bus.remainder;
      z = bus.div_by_zero;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero} !== 39'd0) begin
         bad++;
         $display("FAIL reset_outputs: got q=%h r=%h busy=%b done=%b dbz=%b, want all 0",
                  bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero);
      end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      int lat; logic [23:0] q; logic [11:0] r; logic z;
      do_div(24'd100, 12'd7, lat, q, r, z);
      total++;
      if (lat !== 25 || q !== 24'd14 || r !== 12'd2 || z !== 1'b0) begin
         bad++;
         $display("FAIL basic_100_7: got lat=%0d q=%0d r=%0d z=%b, want lat=25 q=14 r=2 z=0", lat, q, r, z);
      end
      total++;
      if (bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL busy_after_fin: got %b want 0", bus.busy);
      end
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (bus.quotient !== 24'd14 || bus.remainder !== 12'd2) begin
         bad++;
         $display("FAIL result_hold: got q=%0d r=%0d want q=14 r=2", bus.quotient, bus.remainder);
      end
   endtask

   task automatic test_max();
      int lat; logic [23:0] q; logic [11:0] r; logic z;
      do_div(24'hFFFFFF, 12'hFFF, lat, q, r, z);
      total++;
      if (lat !== 25 || q !== 24'h001001 || r !== 12'h000 || z !== 1'b0) begin
         bad++;
         $display("FAIL max_operands: got lat=%0d q=%h r=%h z=%b, want lat=25 q=001001 r=000 z=0", lat, q, r, z);
      end
   endtask

   task automatic test_div_zero();
      int lat; logic [23:0] q; logic [11:0] r; logic z;
      do_div(24'd1234, 12'd0, lat, q, r, z);
      total++;
      if (lat !== 1 || q !== 24'hFFFFFF || r !== 12'hFFF || z !== 1'b1) begin
         bad++;
         $display("FAIL div_zero: got lat=%0d q=%h r=%h z=%b, want lat=1 q=ffffff r=fff z=1", lat, q, r, z);
      end
   endtask

   task automatic test_boundary();
      logic [23:0] av [4] = '{24'd0, 24'hFFFFFF, 24'd5, 24'd4095};
      logic [11:0] bv [4] = '{12'd1, 12'd1, 12'hFFF, 12'd4095};
      for (int i = 0; i < 4; i++) begin
         int lat; logic [23:0] q; logic [11:0] r; logic z;
         logic [23:0] eq; logic [11:0] er;
         eq = av[i] / 24'(bv[i]);
         er = 12'(av[i] % 24'(bv[i]));
         do_div(av[i], bv[i], lat, q, r, z);
         total++;
         if (lat !== 25 || q !== eq || r !== er || z !== 1'b0) begin
            bad++;
            $display("FAIL boundary_%0d: got lat=%0d q=%h r=%h z=%b, want lat=25 q=%h r=%h z=0",
                     i, lat, q, r, z, eq, er);
         end
      end
   endtask

   task automatic test_ignore_start();
      int dones = 0;
      logic [23:0] q = '0; logic [11:0] r = '0; logic z = 1'b1;
      @(negedge clk);
      bus.dividend = 24'd100;
      bus.divisor  = 12'd7;
      bus.start    = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         if (bus.done) begin
            dones++;
            q = bus.quotient; r = bus.remainder; z = bus.div_by_zero;
         end
         if (i == 4) begin
            bus.dividend = 24'd999; bus.divisor = 12'd3; bus.start = 1'b1;
         end else if (i == 9) begin
            bus.dividend = 24'd5; bus.divisor = 12'd0; bus.start = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk); #1;
      end
      total++;
      if (dones !== 1 || q !== 24'd14 || r !== 12'd2 || z !== 1'b0) begin
         bad++;
         $display("FAIL ignore_start: got dones=%0d q=%0d r=%0d z=%b, want dones=1 q=14 r=2 z=0", dones, q, r, z);
      end
   endtask

   task automatic test_reset_mid_run();
      int dones = 0;
      int lat; logic [23:0] q; logic [11:0] r; logic z;
      @(negedge clk);
      bus.dividend = 24'd100;
      bus.divisor  = 12'd7;
      bus.start    = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int i = 1; i < 11; i++) begin
         @(posedge clk); #1;
      end
      total++;
      if (bus.busy !== 1'b1) begin
         bad++;
         $display("FAIL busy_in_run: got %b want 1", bus.busy);
      end
      reset     = 1'b1;
      bus.start = 1'b1;
      @(posedge clk); #1;
      reset     = 1'b0;
      bus.start = 1'b0;
      total++;
      if ({bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero} !== 39'd0) begin
         bad++;
         $display("FAIL reset_mid_run: got q=%h r=%h busy=%b done=%b dbz=%b, want all 0",
                  bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero);
      end
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (bus.done) dones++;
      end
      total++;
      if (dones !== 0) begin
         bad++;
         $display("FAIL no_done_after_reset: got %0d dones want 0", dones);
      end
      do_div(24'd50, 12'd5, lat, q, r, z);
      total++;
      if (lat !== 25 || q !== 24'd10 || r !== 12'd0 || z !== 1'b0) begin
         bad++;
         $display("FAIL after_reset_50_5: got lat=%0d q=%0d r=%0d z=%b, want lat=25 q=10 r=0 z=0", lat, q, r, z);
      end
   endtask

   task automatic test_back_to_back();
      int seen[$];
      int lat = 1;
      logic [23:0] a; logic [11:0] b;
      int errs = 0;
      a = 24'($urandom);
      b = 12'($urandom_range(1, 4095));
      @(negedge clk);
      bus.dividend = a;
      bus.divisor  = b;
      bus.start    = 1'b1;
      @(posedge clk); #1;
      while (seen.size() < 3 && lat < 120) begin
         if (bus.done) begin
            seen.push_back(lat);
            if (bus.quotient !== a / 24'(b) || bus.remainder !== 12'(a % 24'(b))) errs++;
            if (seen.size() == 3) bus.start = 1'b0;
         end
         if (seen.size() < 3) begin
            @(posedge clk); #1;
            lat++;
         end
      end
      bus.start = 1'b0;
      @(posedge clk); #1;
      total++;
      if (seen.size() !== 3 || seen[0] !== 25 || seen[1] !== 51 || seen[2] !== 77 || errs !== 0) begin
         bad++;
         $display("FAIL back_to_back: got %0d dones at %p, %0d value errors; want dones at 25 51 77, 0 errors",
                  seen.size(), seen, errs);
      end
   endtask

   task automatic test_roundtrip();
      int lat; logic [23:0] q; logic [11:0] r; logic z;
      logic [11:0] ma = 12'hABC;
      logic [11:0] mb = 12'h123;
      logic [23:0] prod;
      prod = 24'(ma) * 24'(mb);
      do_div(prod, mb, lat, q, r, z);
      total++;
      if (q !== 24'(ma) || r !== 12'd0 || z !== 1'b0) begin
         bad++;
         $display("FAIL roundtrip_abc_123: got q=%h r=%h z=%b, want q=000abc r=000 z=0", q, r, z);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 1000; n++) begin
         int lat; logic [23:0] q; logic [11:0] r; logic z;
         logic [23:0] a; logic [11:0] b;
         longint recon;
         a = 24'($urandom);
         b = (n % 4 == 0) ? 12'($urandom_range(1, 15)) : 12'($urandom_range(1, 4095));
         do_div(a, b, lat, q, r, z);
         recon = longint'(q) * longint'(b) + longint'(r);
         total++;
         if (lat !== 25 || z !== 1'b0 || r >= b || recon != longint'(a)
             || q !== a / 24'(b)) begin
            bad++;
            $display("FAIL random_%0d: a=%h b=%h got lat=%0d q=%h r=%h z=%b, want q=%h r=%h",
                     n, a, b, lat, q, r, z, a / 24'(b), 12'(a % 24'(b)));
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_max();
      test_div_zero();
      test_boundary();
      test_ignore_start();
      test_reset_mid_run();
      test_back_to_back();
      test_roundtrip();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
